pixel_stream_gen: RTL and testbench

//  Upstream source for the sharpening filter: reads one stored frame from a

---
 rtl/pixel_stream_gen_pkg.sv | 28 ++
 rtl/pixel_stream_gen_if.sv | 31 +++
 rtl/pixel_stream_gen.sv | 141 ++++++++++++++
 tb/tb_pixel_stream_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_gen_pkg.sv
// Shared frame geometry and generator state encoding.
// Pixel width, image size and default blanking live here so that the
// generator, the sharpening filter and their benches all agree on them.
package pixel_stream_gen_pkg;

  localparam int IMG_DATA_WIDTH = 8;
  localparam int IMG_WIDTH      = 4;
  localparam int IMG_HEIGHT     = 4;
  localparam int IMG_H_BLANK    = 2;
  localparam int IMG_V_BLANK    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRE    = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBL    = 3'd3,
    ST_VBL    = 3'd4,
    ST_DONE   = 3'd5
  } gen_state_t;

  // The largest of the three phase lengths sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pixel_stream_gen_if.sv
// Bus bundle between the pixel stream generator, its frame memory and the
// downstream filter.
//   mem_rd_en   generator -> memory   read strobe
//   mem_addr    generator -> memory   linear pixel address
//   mem_rd_data memory -> generator   read data, one cycle after mem_rd_en
//   o_hav       generator -> filter   horizontal active
//   o_vav       generator -> filter   vertical active (frame window)
//   o_data      generator -> filter   pixel value
interface pixel_stream_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 4
);

  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  o_hav;
  logic                  o_vav;
  logic [DATA_WIDTH-1:0] o_data;

  modport master (
    output mem_rd_en, mem_addr, o_hav, o_vav, o_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_en, mem_addr, o_hav, o_vav, o_data,
    output mem_rd_data
  );

endinterface

// File: rtl/pixel_stream_gen.sv
// Pixel stream generator: reads one stored frame from a synchronous frame
// memory and emits it in raster order with hav/vav framing, including
// horizontal blanking before and between rows and vertical blanking after
// the last row, so the downstream filter can flush its last row.
// Ports:
//   clk        clock, rising edge
//   rstb       asynchronous active-low reset
//   start      one-cycle frame request, honoured only when idle
//   bus        master side of pixel_stream_gen_if (memory read + pixel out)
//   busy       high while a frame is in progress
//   frame_done one-cycle pulse at the end of vertical blanking
module pixel_stream_gen
  import pixel_stream_gen_pkg::*;
#(
  parameter int DATA_WIDTH  = IMG_DATA_WIDTH,
  parameter int WIDTH_IMAG  = IMG_WIDTH,
  parameter int HEIGHT_IMAG = IMG_HEIGHT,
  parameter int H_BLANK     = IMG_H_BLANK,
  parameter int V_BLANK     = IMG_V_BLANK
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                start,
  pixel_stream_gen_if.master  bus,
  output logic                busy,
  output logic                frame_done
);

  localparam int ADDR_W = $clog2(WIDTH_IMAG * HEIGHT_IMAG);
  localparam int CNT_W  = $clog2(max3(H_BLANK, WIDTH_IMAG, V_BLANK));
  localparam int ROW_W  = (HEIGHT_IMAG > 1) ? $clog2(HEIGHT_IMAG) : 1;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(WIDTH_IMAG - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_BLANK - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT_IMAG - 1);

  if (H_BLANK < 1 || V_BLANK < WIDTH_IMAG + 4) begin : g_bad_params
    $error("pixel_stream_gen: need H_BLANK >= 1 and V_BLANK >= WIDTH_IMAG+4");
  end

  gen_state_t                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      raw_hav, raw_vav;
  logic                      hav_p1_q, hav_p1_d;
  logic                      vav_p1_q, vav_p1_d;
  logic                      hav_p2_q, hav_p2_d;
  logic                      vav_p2_q, vav_p2_d;
  logic signed [DATA_WIDTH-1:0] data_p2_q, data_p2_d;

  logic last_pix;
  assign last_pix = (cnt_q == W_LAST) && (row_q == ROW_LAST);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_PRE;
      ST_PRE:    if (cnt_q == H_LAST) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cnt_q == W_LAST) state_d = (row_q == ROW_LAST) ? ST_VBL : ST_HBL;
      ST_HBL:    if (cnt_q == H_LAST) state_d = ST_ACTIVE;
      ST_VBL:    if (cnt_q == V_LAST) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Phase counter restarts on every state change; the address counter
  // saturates on the final pixel so it stays put through blanking.
  always_comb begin
    cnt_d  = cnt_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (state_q == ST_IDLE) begin
      if (start) begin
        cnt_d  = '0;
        row_d  = '0;
        addr_d = '0;
      end
    end else if (state_d != state_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == ST_ACTIVE) begin
      if (!last_pix) addr_d = addr_q + 1'b1;
      if (cnt_q == W_LAST && row_q != ROW_LAST) row_d = row_q + 1'b1;
    end
  end

  // Moore output decode
  always_comb begin
    raw_hav       = (state_q == ST_ACTIVE);
    raw_vav       = (state_q == ST_PRE) || (state_q == ST_ACTIVE) || (state_q == ST_HBL);
    busy          = (state_q != ST_IDLE);
    frame_done    = (state_q == ST_DONE);
    bus.mem_rd_en = raw_hav;
    bus.mem_addr  = addr_q;
  end

  // Output pipeline: p1 aligns framing with memory read data, p2 registers
  // the filter-facing outputs. hav is gated with vav so it can never lead it.
  always_comb begin
    hav_p1_d  = raw_hav;
    vav_p1_d  = raw_vav;
    hav_p2_d  = hav_p1_q & vav_p1_q;
    vav_p2_d  = vav_p1_q;
    data_p2_d = hav_p1_q ? bus.mem_rd_data : '0;
  end

  assign bus.o_hav  = hav_p2_q;
  assign bus.o_vav  = vav_p2_q;
  assign bus.o_data = data_p2_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      hav_p1_q  <= 1'b0;
      vav_p1_q  <= 1'b0;
      hav_p2_q  <= 1'b0;
      vav_p2_q  <= 1'b0;
      data_p2_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
      hav_p1_q  <= hav_p1_d;
      vav_p1_q  <= vav_p1_d;
      hav_p2_q  <= hav_p2_d;
      vav_p2_q  <= vav_p2_d;
      data_p2_q <= data_p2_d;
    end
  end

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Directed bench for pixel_stream_gen (4x4 frame, H_BLANK=2, V_BLANK=8,
// frame memory holds mem[a] = a+1).
module tb_pixel_stream_gen;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int HB = 2;
  localparam int VB = 8;
  localparam int VAV_LEN   = HB + H * W + (H - 1) * HB;  // 24
  localparam int FRAME_LEN = VAV_LEN + VB + 1;           // 33

  logic clk;
  logic rstb;
  logic start;
  logic busy;
  logic frame_done;

  int n_assert = 0;
  int n_fail   = 0;

  pixel_stream_gen_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus_if ();

  pixel_stream_gen #(
    .DATA_WIDTH (DW),
    .WIDTH_IMAG (W),
    .HEIGHT_IMAG(H),
    .H_BLANK    (HB),
    .V_BLANK    (VB)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .start     (start),
    .bus       (bus_if),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // Synchronous frame memory model: mem[a] = a + 1
  always_ff @(posedge clk) begin
    if (bus_if.mem_rd_en) bus_if.mem_rd_data <= {4'h0, bus_if.mem_addr} + 8'd1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference raster timing at raw (pre-pipeline) level, t cycles after
  // the start-accept edge.
  function automatic void raw_pix(input int t, output bit hv, output bit vv, output int idx);
    int p, r, c;
    hv  = 1'b0;
    idx = 0;
    vv  = (t >= 0) && (t < VAV_LEN);
    if (t >= HB) begin
      p = t - HB;
      r = p / (W + HB);
      c = p % (W + HB);
      if (r < H && c < W) begin
        hv  = 1'b1;
        idx = r * W + c;
      end
    end
  endfunction

  // Launch a frame and check ncyc cycles of it. restart_k re-pulses start
  // during that cycle; keep_start leaves start high throughout.
  task automatic run_frame(input string tag, input int ncyc, input int restart_k, input bit keep_start);
    bit hv, vv, rhv, rvv;
    int idx, ridx;
    logic [11:0] exp_o, obs_o;
    logic [4:0]  exp_m, obs_m;
    int bursts = 0, run = 0, gap = 0, burst_bad = 0, gap_bad = 0;
    int hav_cnt = 0, done_cnt = 0, vlow = 0;
    bit seen_vav = 0, prev_hav = 0;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      raw_pix(k - 2, hv, vv, idx);
      exp_o = {(k < FRAME_LEN), (k == FRAME_LEN - 1), vv, hv, (hv ? 8'(idx + 1) : 8'h00)};
      obs_o = {busy, frame_done, bus_if.o_vav, bus_if.o_hav, bus_if.o_data};
      check($sformatf("%s out k=%0d {busy,done,vav,hav,data}", tag, k), 32'(obs_o), 32'(exp_o));
      raw_pix(k, rhv, rvv, ridx);
      exp_m = {rhv, (rhv ? 4'(ridx) : 4'h0)};
      obs_m = {bus_if.mem_rd_en, (bus_if.mem_rd_en ? bus_if.mem_addr : 4'h0)};
      check($sformatf("%s mem k=%0d {rd_en,addr}", tag, k), 32'(obs_m), 32'(exp_m));
      // Observed framing statistics
      if (bus_if.o_hav) begin
        hav_cnt++;
        if (!prev_hav) begin
          if (bursts > 0 && gap != HB) gap_bad++;
          bursts++;
          run = 0;
        end
        run++;
        gap = 0;
      end else begin
        if (prev_hav && run != W) burst_bad++;
        gap++;
      end
      prev_hav = bus_if.o_hav;
      if (bus_if.o_vav) seen_vav = 1'b1;
      if (seen_vav && !bus_if.o_vav && done_cnt == 0 && !frame_done) vlow++;
      if (frame_done) done_cnt++;
      if (!keep_start) start = (k == restart_k);
    end
    if (ncyc >= FRAME_LEN) begin
      check({tag, " hav cycles"}, 32'(hav_cnt), 32'(H * W));
      check({tag, " hav bursts"}, 32'(bursts), 32'(H));
      check({tag, " bad burst lengths"}, 32'(burst_bad), 32'd0);
      check({tag, " bad row gaps"}, 32'(gap_bad), 32'd0);
      check({tag, " frame_done pulses"}, 32'(done_cnt), 32'd1);
      check({tag, " vav low before done >= VB-2"}, 32'(vlow >= VB - 2), 32'd1);
    end
  endtask

  task automatic check_idle(input string tag, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check($sformatf("%s idle %0d", tag, i),
            32'({busy, frame_done, bus_if.mem_rd_en, bus_if.o_vav, bus_if.o_hav, bus_if.o_data}),
            32'd0);
    end
  endtask

  initial begin
    rstb  = 1'b0;
    start = 1'b0;
    #12;
    check("reset outputs",
          32'({busy, frame_done, bus_if.mem_rd_en, bus_if.o_vav, bus_if.o_hav, bus_if.o_data, bus_if.mem_addr}),
          32'd0);
    @(negedge clk);
    rstb = 1'b1;
    check_idle("post-reset", 3);

    // Single frame, then a frame with a mid-frame start that is ignored,
    // followed immediately by a start in the cycle after frame_done.
    run_frame("f1", FRAME_LEN + 3, -1, 1'b0);
    run_frame("f2_restart", FRAME_LEN + 1, 16, 1'b0);
    run_frame("f3_after_done", FRAME_LEN + 3, -1, 1'b0);

    // Abort during row 1 with an asynchronous reset.
    run_frame("f4_abort", 10, -1, 1'b0);
    #2;
    rstb = 1'b0;
    #1;
    check("async reset mid-frame",
          32'({busy, frame_done, bus_if.mem_rd_en, bus_if.o_vav, bus_if.o_hav, bus_if.o_data, bus_if.mem_addr}),
          32'd0);
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    check_idle("post-abort", 4);
    run_frame("f5_restart_addr0", FRAME_LEN + 3, -1, 1'b0);

    // start held high: back-to-back frames with one idle cycle between.
    run_frame("f6_held", FRAME_LEN + 1, -1, 1'b1);
    run_frame("f7_held", FRAME_LEN + 1, -1, 1'b1);
    run_frame("f8_held", FRAME_LEN + 1, -1, 1'b1);
    start = 1'b0;
    check_idle("final", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
